// File: rtl/l1_l2_arbiter_if.sv
// Shared request package and request-port interface for the L1/L2 arbiter.
// Ports: req_valid/req_type/req_address/req_wdata travel from requester to
// responder; req_fulfilled is the per-beat completion pulse coming back.
package l1_l2_arbiter_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

interface l1_l2_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import l1_l2_arbiter_pkg::*;

    logic                  req_valid;
    memory_operation_e     req_type;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_fulfilled;

    // Requester side: issues beats, receives completion.
    modport master (
        output req_valid, req_type, req_address, req_wdata,
        input  req_fulfilled
    );

    // Responder side.
    modport slave (
        input  req_valid, req_type, req_address, req_wdata,
        output req_fulfilled
    );

    // Responder side for a read-only requester (write data never consumed).
    modport slave_nowd (
        input  req_valid, req_type, req_address,
        output req_fulfilled
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Purpose: locks the single L2 request port to the I- or D-cache controller for a whole
//          multi-beat transaction, round-robin on contention. Ports: clk, reset, icache/dcache
//          (responder side), l2 (requester side), icache_granted/dcache_granted status.
// Latency: grant one cycle after valid from idle; fulfilled is a zero-latency passthrough.
// Backpressure: owner holds the L2 while valid stays high; one bubble cycle between owners.
module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    l1_l2_arbiter_if.slave_nowd     icache,
    l1_l2_arbiter_if.slave          dcache,
    l1_l2_arbiter_if.master         l2,
    output logic                    icache_granted,
    output logic                    dcache_granted
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_e;

    state_e r_state;
    state_e w_next_state;
    logic   r_last_grant;      // 0 = I owned last, 1 = D owned last
    logic   w_next_last_grant;

    logic                  w_l2_valid;
    memory_operation_e     w_l2_type;
    logic [ADDR_WIDTH-1:0] w_l2_address;
    logic [DATA_WIDTH-1:0] w_l2_wdata;
    logic                  w_i_fulfilled;
    logic                  w_d_fulfilled;
    logic                  w_i_granted;
    logic                  w_d_granted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_l2_valid        = 1'b0;
        w_l2_type         = LOAD;
        w_l2_address      = '0;
        w_l2_wdata        = '0;
        w_i_fulfilled     = 1'b0;
        w_d_fulfilled     = 1'b0;
        w_i_granted       = 1'b0;
        w_d_granted       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // On contention hand the port to whoever did not own it last.
                if (icache.req_valid && (!dcache.req_valid || r_last_grant)) begin
                    w_next_state      = ST_GRANT_I;
                    w_next_last_grant = 1'b0;
                end else if (dcache.req_valid) begin
                    w_next_state      = ST_GRANT_D;
                    w_next_last_grant = 1'b1;
                end
            end

            ST_GRANT_I: begin
                w_i_granted = 1'b1;
                if (icache.req_valid) begin
                    w_l2_valid    = 1'b1;
                    w_l2_type     = icache.req_type;
                    w_l2_address  = icache.req_address;
                    w_i_fulfilled = l2.req_fulfilled;
                end else if (dcache.req_valid) begin
                    // Release cycle doubles as the handoff bubble.
                    w_next_state      = ST_GRANT_D;
                    w_next_last_grant = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_GRANT_D: begin
                w_d_granted = 1'b1;
                // Type may flip STORE->LOAD mid-ownership (writeback then fill).
                if (dcache.req_valid) begin
                    w_l2_valid    = 1'b1;
                    w_l2_type     = dcache.req_type;
                    w_l2_address  = dcache.req_address;
                    w_l2_wdata    = dcache.req_wdata;
                    w_d_fulfilled = l2.req_fulfilled;
                end else if (icache.req_valid) begin
                    w_next_state      = ST_GRANT_I;
                    w_next_last_grant = 1'b0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                // Unreachable from reset; poison everything so it shows up in simulation.
                w_next_state      = state_e'('x);
                w_next_last_grant = 1'bx;
                w_l2_valid        = 1'bx;
                w_l2_type         = memory_operation_e'('x);
                w_l2_address      = 'x;
                w_l2_wdata        = 'x;
                w_i_fulfilled     = 1'bx;
                w_d_fulfilled     = 1'bx;
                w_i_granted       = 1'bx;
                w_d_granted       = 1'bx;
            end
        endcase
    end

    assign l2.req_valid           = w_l2_valid;
    assign l2.req_type            = w_l2_type;
    assign l2.req_address         = w_l2_address;
    assign l2.req_wdata           = w_l2_wdata;
    assign icache.req_fulfilled   = w_i_fulfilled;
    assign dcache.req_fulfilled   = w_d_fulfilled;
    assign icache_granted         = w_i_granted;
    assign dcache_granted         = w_d_granted;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
module tb_l1_l2_arbiter;
    import l1_l2_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic icache_granted;
    logic dcache_granted;

    l1_l2_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ic_if ();
    l1_l2_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dc_if ();
    l1_l2_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) l2_if ();

    l1_l2_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache         (ic_if),
        .dcache         (dc_if),
        .l2             (l2_if),
        .icache_granted (icache_granted),
        .dcache_granted (dcache_granted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              to_d;
        memory_operation_e op;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     wdata;
    } beat_t;

    beat_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Drive one beat on the selected requester with L2 completing it this cycle.
    task automatic drive_beat(input logic to_d, input memory_operation_e op,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        beat_t b;
        b.to_d  = to_d;
        b.op    = op;
        b.addr  = addr;
        b.wdata = to_d ? wdata : '0;
        if (to_d) begin
            dc_if.req_type    = op;
            dc_if.req_address = addr;
            dc_if.req_wdata   = wdata;
        end else begin
            ic_if.req_type    = op;
            ic_if.req_address = addr;
        end
        l2_if.req_fulfilled = 1'b1;
        sb_q.push_back(b);
    endtask

    task automatic check_beat(input string tag);
        beat_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_valid"}, l2_if.req_valid, 1'b1);
        chk({tag, "_type"},  l2_if.req_type,  e.op);
        chk({tag, "_addr"},  l2_if.req_address, e.addr);
        chk({tag, "_wdata"}, l2_if.req_wdata, e.wdata);
        chk({tag, "_ifull"}, ic_if.req_fulfilled, !e.to_d);
        chk({tag, "_dfull"}, dc_if.req_fulfilled, e.to_d);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_l2v"},   l2_if.req_valid, 1'b0);
        chk({tag, "_ifull"}, ic_if.req_fulfilled, 1'b0);
        chk({tag, "_dfull"}, dc_if.req_fulfilled, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_quiet(tag);
        chk({tag, "_type"}, l2_if.req_type, LOAD);
        chk({tag, "_addr"}, l2_if.req_address, 0);
        chk({tag, "_wd"},   l2_if.req_wdata, 0);
        chk({tag, "_ig"},   icache_granted, 1'b0);
        chk({tag, "_dg"},   dcache_granted, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        ic_if.req_valid = 1'b0; ic_if.req_type = LOAD; ic_if.req_address = '0; ic_if.req_wdata = '0;
        dc_if.req_valid = 1'b0; dc_if.req_type = LOAD; dc_if.req_address = '0; dc_if.req_wdata = '0;
        l2_if.req_valid = 1'b0; l2_if.req_type = LOAD; l2_if.req_address = '0; l2_if.req_wdata = '0;
        l2_if.req_fulfilled = 1'b0;
        next_cycle(); next_cycle();
        sample();
        check_idle_outputs("reset");

        // ---- Only I requests, 4 beats ----
        next_cycle(); reset = 1'b0; ic_if.req_valid = 1'b1; ic_if.req_address = 32'h100;
        sample();
        check_idle_outputs("i_req_cycle0");
        for (int k = 0; k < 4; k++) begin
            next_cycle(); drive_beat(1'b0, LOAD, 32'h100 + 32'(4 * k), '0);
            sample();
            chk("i_only_granted", icache_granted, 1'b1);
            check_beat("i_only_beat");
        end
        next_cycle(); ic_if.req_valid = 1'b0;  // release; fulfilled still high
        sample();
        check_quiet("i_release_ignored");
        next_cycle();                           // idle, fulfilled still high
        sample();
        check_idle_outputs("idle_ignored");
        l2_if.req_fulfilled = 1'b0;

        // ---- Contention after reset history: last_grant=I -> D first ----
        next_cycle(); ic_if.req_valid = 1'b1; dc_if.req_valid = 1'b1;
        ic_if.req_address = 32'h200; dc_if.req_address = 32'h300;
        sample();
        chk("cont_idle_l2v", l2_if.req_valid, 1'b0);
        for (int k = 0; k < 2; k++) begin
            next_cycle(); drive_beat(1'b1, LOAD, 32'h300 + 32'(4 * k), 32'h55);
            sample();
            chk("cont_d_granted", dcache_granted, 1'b1);
            chk("cont_i_not_granted", icache_granted, 1'b0);
            check_beat("cont_d_beat");
        end
        next_cycle(); dc_if.req_valid = 1'b0; l2_if.req_fulfilled = 1'b0;
        sample();
        check_quiet("cont_bubble");
        next_cycle(); drive_beat(1'b0, LOAD, 32'h200, '0);
        sample();
        chk("cont_i_granted", icache_granted, 1'b1);
        check_beat("cont_i_beat");
        next_cycle(); ic_if.req_valid = 1'b0; l2_if.req_fulfilled = 1'b0;
        sample();
        check_quiet("cont_i_release");

        // ---- Contention again (last=I): D writeback then fill, I waits ----
        next_cycle(); ic_if.req_valid = 1'b1; dc_if.req_valid = 1'b1;
        sample();
        chk("wb_idle_dg", dcache_granted, 1'b0);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k < 4) drive_beat(1'b1, STORE, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k));
            else       drive_beat(1'b1, LOAD,  32'h800 + 32'(4 * (k - 4)), 32'hEE);
            sample();
            chk("wb_d_held", dcache_granted, 1'b1);
            chk("wb_i_waits", icache_granted, 1'b0);
            check_beat("wb_beat");
        end
        next_cycle(); dc_if.req_valid = 1'b0; l2_if.req_fulfilled = 1'b1;
        sample();
        check_quiet("wb_release");
        next_cycle(); l2_if.req_fulfilled = 1'b0;
        sample();
        chk("wb_handoff_ig", icache_granted, 1'b1);
        chk("wb_handoff_l2v", l2_if.req_valid, 1'b1);
        next_cycle(); ic_if.req_valid = 1'b0;
        sample();
        check_quiet("wb_i_release");
        next_cycle();
        sample();
        check_idle_outputs("wb_back_idle");

        // ---- Reset mid-D transfer ----
        next_cycle(); dc_if.req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_cycle(); drive_beat(1'b1, STORE, 32'hC00 + 32'(4 * k), 32'hB0 + 32'(k));
            sample();
            check_beat("rst_d_beat");
        end
        next_cycle(); reset = 1'b1; l2_if.req_fulfilled = 1'b0;
        sample();
        next_cycle(); reset = 1'b0;
        sample();
        check_idle_outputs("rst_after");
        next_cycle();
        sample();
        chk("rst_regrant_dg", dcache_granted, 1'b1);
        chk("rst_regrant_l2v", l2_if.req_valid, 1'b1);
        chk("rst_regrant_type", l2_if.req_type, STORE);
        next_cycle(); dc_if.req_valid = 1'b0;
        sample();
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

Two-requester arbiter sharing the single L2 request port between the instruction-cache controller (port I) and the data-cache controller (port D). It locks the L2 to one requester for the whole multi-beat transaction (line fill, writeback, or writeback followed by fill) and alternates ownership round-robin on contention. It passes through request type, address and write data, and steers `l2_req_fulfilled` back to the owner only. It sits between the L1 controllers/datapaths and the L2 controller.

## Interface
- ADDR_WIDTH, 32, byte address width of the L2 request
- DATA_WIDTH, 32, width of one L2 write beat
- clk  input  1  clock; all state changes on posedge
- reset  input  1  synchronous, active-high
- icache_req_valid  input  1  I requester wants/holds the L2; held high for the whole transaction
- icache_req_type  input  memory_operation_e  I operation (LOAD in practice)
- icache_req_address  input  ADDR_WIDTH  I beat address
- icache_req_fulfilled  output  1  beat-complete pulse to I
- dcache_req_valid  input  1  D requester wants/holds the L2
- dcache_req_type  input  memory_operation_e  D operation (LOAD or STORE)
- dcache_req_address  input  ADDR_WIDTH  D beat address
- dcache_req_wdata  input  DATA_WIDTH  D write beat data
- dcache_req_fulfilled  output  1  beat-complete pulse to D
- l2_req_valid  output  1  request to L2
- l2_req_type  output  memory_operation_e  operation to L2
- l2_req_address  output  ADDR_WIDTH  address to L2
- l2_req_wdata  output  DATA_WIDTH  write data to L2
- l2_req_fulfilled  input  1  L2 beat completion
- icache_granted  output  1  state is ST_GRANT_I
- dcache_granted  output  1  state is ST_GRANT_D

## Operation
- States: ST_IDLE, ST_GRANT_I, ST_GRANT_D. Registered `last_grant` bit (0 = I, 1 = D) records the most recent owner.
- ST_IDLE: L2 outputs inactive (l2_req_valid=0, l2_req_type=LOAD, address/wdata=0). Arbitration:
  - only I valid -> ST_GRANT_I; only D valid -> ST_GRANT_D;
  - both valid -> grant the port not equal to last_grant;
  - none -> stay.
  - last_grant updates on the transition into a grant state.
- ST_GRANT_X (X = owner) while X_req_valid=1:
  - l2_req_valid=1, l2_req_type/address = X's inputs;
  - wdata = dcache_req_wdata for D, 0 for I;
  - X_req_fulfilled = l2_req_fulfilled; other port's fulfilled = 0;
  - stay in ST_GRANT_X regardless of the other port and of type changes (D writeback STORE beats followed by LOAD fill beats stay one transaction).
- ST_GRANT_X with X_req_valid=0 (release cycle):
  - l2_req_valid=0, both fulfilled=0;
  - other port valid -> ST_GRANT_other directly (last_grant updated); else -> ST_IDLE.
- l2_req_fulfilled while in ST_IDLE, or during a release cycle, is ignored; it is never forwarded.
- Requester ports are never gated by a combinational path from their own fulfilled; the owner's valid is forwarded unchanged.
- Illegal state encodings drive all outputs X and next state X in simulation; they are unreachable from reset.
- Reset: state=ST_IDLE and last_grant=0 (I), so the first contended grant goes to D. All outputs 0 (l2_req_type=LOAD) and both granted flags 0. A reset during a transaction drops ownership with no completion pulse.

## Timing
- Grant latency from idle: X_req_valid rises in cycle N -> X_granted and l2_req_valid high in cycle N+1.
- Fulfilled passthrough is combinational, with zero added latency: l2_req_fulfilled in cycle M -> X_req_fulfilled in cycle M.
- Handoff: owner drops valid in cycle R (the release cycle, with l2_req_valid=0). A waiting requester sees l2_req_valid=1 in cycle R+1. There is exactly one bubble cycle between owners.
- Back-to-back from the same requester: the owner drops valid for at least one cycle and re-requests. If the other port is waiting, the other port is served first.
- Starvation bound: a waiting port is granted within one release cycle of the current owner finishing.

## Test plan
- Only I requests, L2 fulfills 4 beats at 1 beat/cycle. Required: icache_granted=1 from cycle 1, 4 icache_req_fulfilled pulses, dcache_req_fulfilled=0 throughout, return to ST_IDLE after I drops valid.
- I and D both request in the same cycle after reset. Required: D granted first (last_grant=0). After D releases, I is granted with exactly one bubble cycle, and last_grant alternates.
- D does 4 STORE beats (wdata 0xA0..0xA3) then 4 LOAD beats with valid held high, while I waits. Required: l2_req_wdata tracks D, type switches STORE->LOAD, no grant to I until D drops valid.
- l2_req_fulfilled pulsed in ST_IDLE and in a release cycle. Required: no fulfilled output pulses.
- Reset asserted mid-D transfer after 2 of 4 beats. Required: next cycle state=ST_IDLE, all outputs 0/LOAD. A held D request is re-granted one cycle after reset deasserts.
